print_out_uart_tx: RTL and testbench

Synthesizable consumer for the CPU wrapper's 49-bit console strobe bus (print_out). It captures each strobed character into a small FIFO and serializes it on a UART TX line as 8N1, LSB first. This lets on-board builds emit the same console text that simulation prints with $write. It sits next to picorv32_wrapper at the top level and is driven directly by its print_out output.

---
 rtl/print_out_uart_tx_if.sv | 22 ++
 rtl/print_out_uart_tx.sv | 133 +++++++++++++
 tb/tb_print_out_uart_tx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/print_out_uart_tx_if.sv
// Console strobe bus into the UART printer, plus its serial line and status.
// Handshake: print_in[48] is a one-cycle valid with no ready; a strobe the FIFO cannot hold is dropped and flagged.
interface print_out_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [48:0]      print_in;
    logic             uart_tx;
    logic             busy;
    logic             overflow;
    logic [FIFO_AW:0] fifo_level;
    logic [1:0]       fsm_state;

    modport master (
        output print_in,
        input  uart_tx, busy, overflow, fifo_level, fsm_state
    );

    modport slave (
        input  print_in,
        output uart_tx, busy, overflow, fifo_level, fsm_state
    );
endinterface

// File: rtl/print_out_uart_tx.sv
// Queues console characters from the CPU print_out strobe bus and sends them as 8N1 UART frames.
module print_out_uart_tx #(
    parameter int CLK_DIV = 868,
    parameter int FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    print_out_uart_tx_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    DIV_M1 = CW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] FULL   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [2:0]          idx, idx_nx;
    logic [7:0]          shift, shift_nx;
    logic                tx, tx_nx;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    level;
    logic                ovf;
    logic                push, pop, accept, bit_end, empty;

    assign push    = bus.print_in[48];
    assign empty   = (level == '0);
    assign bit_end = (cnt == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign accept  = push && ((level != FULL) || pop);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shift_nx = shift;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    cnt_nx   = DIV_M1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nx   = DIV_M1;
                    idx_nx   = 3'd0;
                    state_nx = DATA;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nx   = DIV_M1;
                    shift_nx = shift >> 1;
                    idx_nx   = idx + 3'd1;
                    if (idx == 3'd7) state_nx = STOP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nx = DIV_M1;
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line level is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        tx_nx = 1'b1;
        case (state)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift[0];
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= 3'd0;
            shift  <= 8'd0;
            tx     <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shift <= shift_nx;
            tx    <= tx_nx;
            if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + (FIFO_AW + 1)'(1);
                2'b01:   level <= level - (FIFO_AW + 1)'(1);
                default: level <= level;
            endcase
            ovf <= ovf | (push & ~accept);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.print_in[7:0];
    end

    assign bus.uart_tx    = tx;
    assign bus.busy       = (state != IDLE) || !empty;
    assign bus.overflow   = ovf;
    assign bus.fifo_level = level;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_print_out_uart_tx.sv
// Directed bench for print_out_uart_tx: a fast-baud instance for framing/FIFO cases and a 868-divider smoke instance.
module tb_print_out_uart_tx;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    print_out_uart_tx_if #(.FIFO_AW(4)) sif ();
    print_out_uart_tx_if #(.FIFO_AW(4)) bif ();

    print_out_uart_tx #(.CLK_DIV(4), .FIFO_AW(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    print_out_uart_tx #(.CLK_DIV(868), .FIFO_AW(4)) dut_big (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         fe_q[$];
    int         start_q[$];

    // Line monitor for the CLK_DIV=4 instance: samples each bit mid-way, drops frames cut by reset.
    bit         rst_seen = 1'b0;
    logic [7:0] mon_d;
    bit         mon_fe;
    int         mon_st;
    always @(negedge resetn) rst_seen = 1'b1;
    always begin
        @(negedge clk);
        if (resetn === 1'b1 && sif.uart_tx === 1'b0) begin
            mon_st   = cyc;
            rst_seen = 1'b0;
            mon_fe   = 1'b0;
            mon_d    = 8'h00;
            repeat (2) @(negedge clk);
            if (sif.uart_tx !== 1'b0) mon_fe = 1'b1;
            for (int j = 0; j < 8; j++) begin
                repeat (4) @(negedge clk);
                mon_d[j] = sif.uart_tx;
            end
            repeat (4) @(negedge clk);
            if (sif.uart_tx !== 1'b1) mon_fe = 1'b1;
            @(negedge clk);
            if (!rst_seen) begin
                rx_q.push_back(mon_d);
                fe_q.push_back(mon_fe);
                start_q.push_back(mon_st);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] c);
        sif.print_in = {1'b1, 40'd0, c};
        @(negedge clk);
        sif.print_in = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        fe_q.delete();
        start_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (sif.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sif.busy, 1'b0);
        repeat (45) @(negedge clk);
    endtask

    task automatic score(input string tag);
        logic [7:0] e, g;
        bit         f;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            g = rx_q.pop_front();
            f = fe_q.pop_front();
            chk(tag, g, e);
            chk({tag, "_framing"}, f, 1'b0);
        end
        exp_q.delete();
        rx_q.delete();
        fe_q.delete();
    endtask

    initial begin
        logic [9:0] fb;
        logic       exp_tx;
        int         n, bad;

        resetn       = 1'b0;
        sif.print_in = '0;
        bif.print_in = '0;
        @(negedge clk);
        chk("rst_tx", sif.uart_tx, 1'b1);
        chk("rst_busy", sif.busy, 1'b0);
        chk("rst_ovf", sif.overflow, 1'b0);
        chk("rst_level", sif.fifo_level, 5'd0);
        chk("rst_state", sif.fsm_state, 2'd0);
        do_reset();

        // Single 'A': exact per-cycle waveform relative to the strobe edge.
        fb = {1'b1, 8'h41, 1'b0};
        exp_q.push_back(8'h41);
        strobe(8'h41);
        for (int k = 0; k <= 42; k++) begin
            exp_tx = (k < 2 || k >= 42) ? 1'b1 : fb[(k - 2) / 4];
            chk("a_tx", sif.uart_tx, exp_tx);
            chk("a_busy", sif.busy, (k <= 40) ? 1'b1 : 1'b0);
            if (k == 0) chk("a_level0", sif.fifo_level, 5'd1);
            if (k == 1) begin
                chk("a_level1", sif.fifo_level, 5'd0);
                chk("a_state1", sif.fsm_state, 2'd1);
            end
            @(negedge clk);
        end
        wait_idle("a_idle", 100);
        score("a_rx");

        // "Hi\n" back to back: level peaks at 2, frames abut.
        start_q.delete();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h0A);
        strobe(8'h48);
        chk("hi_level0", sif.fifo_level, 5'd1);
        strobe(8'h69);
        chk("hi_level1", sif.fifo_level, 5'd1);
        strobe(8'h0A);
        chk("hi_level2", sif.fifo_level, 5'd2);
        wait_idle("hi_idle", 300);
        chk("hi_frames", start_q.size(), 3);
        if (start_q.size() >= 3) begin
            chk("hi_gap1", start_q[1] - start_q[0], 40);
            chk("hi_gap2", start_q[2] - start_q[1], 40);
        end
        score("hi_rx");

        // 20 strobes: 17 accepted, 3 dropped, sticky overflow.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            strobe(8'(i));
            if (i == 16) begin
                chk("ovf_level16", sif.fifo_level, 5'd16);
                chk("ovf_not_yet", sif.overflow, 1'b0);
            end
        end
        chk("ovf_level_full", sif.fifo_level, 5'd16);
        chk("ovf_set", sif.overflow, 1'b1);
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
        wait_idle("ovf_idle", 2000);
        chk("ovf_sticky", sif.overflow, 1'b1);
        chk("ovf_drained", sif.fifo_level, 5'd0);
        score("ovf_rx");

        // Push on the pop cycle while full: accepted, level stays 16.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            strobe(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        chk("pp_full", sif.fifo_level, 5'd16);
        repeat (24) @(negedge clk);
        chk("pp_pre_level", sif.fifo_level, 5'd16);
        strobe(8'h31);
        exp_q.push_back(8'h31);
        chk("pp_level", sif.fifo_level, 5'd16);
        chk("pp_ovf", sif.overflow, 1'b0);
        wait_idle("pp_idle", 2000);
        chk("pp_ovf_end", sif.overflow, 1'b0);
        score("pp_rx");

        // Reset mid-DATA with three characters queued.
        do_reset();
        strobe(8'h00);
        strobe(8'h31);
        strobe(8'h32);
        strobe(8'h33);
        chk("mr_level", sif.fifo_level, 5'd3);
        repeat (12) @(negedge clk);
        chk("mr_tx_data", sif.uart_tx, 1'b0);
        chk("mr_state", sif.fsm_state, 2'd2);
        resetn = 1'b0;
        #1;
        chk("mr_tx_high", sif.uart_tx, 1'b1);
        chk("mr_level0", sif.fifo_level, 5'd0);
        chk("mr_busy0", sif.busy, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        chk("mr_no_rx", rx_q.size(), 0);
        chk("mr_idle", sif.busy, 1'b0);
        exp_q.push_back(8'h55);
        strobe(8'h55);
        wait_idle("mr_idle2", 200);
        score("mr_rx");

        // Real divider: 0x0A, each bit exactly 868 stable cycles.
        bif.print_in = {1'b1, 40'd0, 8'h0A};
        @(negedge clk);
        bif.print_in = '0;
        n = 0;
        while (bif.uart_tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("big_latency", n, 2);
        fb = {1'b1, 8'h0A, 1'b0};
        for (int j = 0; j < 10; j++) begin
            bad = 0;
            for (int c = 0; c < 868; c++) begin
                if (bif.uart_tx !== fb[j]) bad++;
                @(negedge clk);
            end
            chk("big_bit", bad, 0);
        end
        chk("big_end_tx", bif.uart_tx, 1'b1);
        chk("big_end_busy", bif.busy, 1'b0);
        chk("big_ovf", bif.overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
